// File: rtl/usb_tx_crc16_seq_if.sv
// Byte-stream bundle between the endpoint TX buffer, the CRC16 sequencer and the serializer.
// The master drives payload in and accepts bytes out; the slave is the sequencer.
interface usb_tx_crc16_seq_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_last;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_last;
    logic       out_ready;

    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_valid, out_last
    );

    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_data, out_valid, out_last
    );
endinterface

// File: rtl/usb_tx_crc16_seq.sv
// USB DATAx transmit sequencer: forwards payload bytes while running a bit-serial CRC16,
// then appends the two inverted, bit-reversed CRC bytes at end of packet.
module usb_tx_crc16_seq #(
    parameter int MAX_BYTES = 1023,
    parameter int CNT_W     = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    input  logic                 start_zlp_i,
    input  logic                 abort_i,
    usb_tx_crc16_seq_if.slave    bus,
    output logic                 busy_o,
    output logic [CNT_W-1:0]     byte_count_o,
    output logic                 overflow_o
);

    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, EMIT, CRC_LO, CRC_HI} state_t;

    state_t             state_q, state_d;
    logic [15:0]        crc_q, crc_d;
    logic [7:0]         byte_q, byte_d;
    logic               last_q, last_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         bit_q, bit_d;
    logic [7:0]         out_data_q, out_data_d;
    logic               out_valid_q, out_valid_d;
    logic               out_last_q, out_last_d;
    logic               in_ready_q, in_ready_d;
    logic               busy_q, busy_d;
    logic               overflow_q, overflow_d;
    logic               fb;
    logic               at_max_q;

    function automatic logic [7:0] bitrev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    assign at_max_q = (cnt_q == CNT_W'(MAX_BYTES));
    assign fb       = byte_q[bit_q] ^ crc_q[15];

    always_comb begin
        state_d    = state_q;
        crc_d      = crc_q;
        byte_d     = byte_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        overflow_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_zlp_i) begin
                    state_d = CRC_LO;
                    crc_d   = 16'hFFFF;
                    cnt_d   = '0;
                end else if (start_i) begin
                    state_d = LOAD;
                    crc_d   = 16'hFFFF;
                    cnt_d   = '0;
                end
            end
            LOAD: begin
                if (bus.in_valid && at_max_q) begin
                    overflow_d = 1'b1;
                    state_d    = IDLE;
                end else if (bus.in_valid && in_ready_q) begin
                    byte_d  = bus.in_data;
                    last_d  = bus.in_last;
                    cnt_d   = cnt_q + CNT_W'(1);
                    bit_d   = 3'd0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // One LFSR step of x^16+x^15+x^2+1, payload bit fed LSB-first
                crc_d[0]    = fb;
                crc_d[1]    = crc_q[0];
                crc_d[2]    = crc_q[1] ^ fb;
                crc_d[14:3] = crc_q[13:2];
                crc_d[15]   = crc_q[14] ^ fb;
                bit_d       = bit_q + 3'd1;
                if (bit_q == 3'd7) state_d = EMIT;
            end
            EMIT: begin
                if (bus.out_ready) state_d = last_q ? CRC_LO : LOAD;
            end
            CRC_LO: begin
                if (bus.out_ready) state_d = CRC_HI;
            end
            CRC_HI: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (abort_i) begin
            state_d    = IDLE;
            crc_d      = 16'hFFFF;
            cnt_d      = '0;
            bit_d      = 3'd0;
            overflow_d = 1'b0;
        end

        // Outputs are derived from the next state so they register in step with it
        out_data_d  = 8'h00;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        case (state_d)
            EMIT: begin
                out_valid_d = 1'b1;
                out_data_d  = byte_d;
            end
            CRC_LO: begin
                out_valid_d = 1'b1;
                out_data_d  = ~bitrev8(crc_d[15:8]);
            end
            CRC_HI: begin
                out_valid_d = 1'b1;
                out_last_d  = 1'b1;
                out_data_d  = ~bitrev8(crc_d[7:0]);
            end
            default: ;
        endcase
        in_ready_d = (state_d == LOAD) && (cnt_d != CNT_W'(MAX_BYTES));
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            crc_q       <= 16'hFFFF;
            byte_q      <= 8'h00;
            last_q      <= 1'b0;
            cnt_q       <= '0;
            bit_q       <= 3'd0;
            out_data_q  <= 8'h00;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            crc_q       <= crc_d;
            byte_q      <= byte_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            overflow_q  <= overflow_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign busy_o        = busy_q;
    assign byte_count_o  = cnt_q;
    assign overflow_o    = overflow_q;

endmodule

// File: tb/tb_usb_tx_crc16_seq.sv
// Scoreboard bench for usb_tx_crc16_seq: expected output bytes are queued as packets are driven
// and popped as the serializer side accepts them; every accepted packet is residual-checked.
module tb_usb_tx_crc16_seq;

    localparam int MAXB  = 4;
    localparam int CNT_W = 10;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             startZlp = 1'b0;
    logic             abort = 1'b0;
    logic             busy;
    logic [CNT_W-1:0] byteCount;
    logic             overflow;

    usb_tx_crc16_seq_if bus();

    usb_tx_crc16_seq #(.MAX_BYTES(MAXB), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start),
        .start_zlp_i  (startZlp),
        .abort_i      (abort),
        .bus          (bus),
        .busy_o       (busy),
        .byte_count_o (byteCount),
        .overflow_o   (overflow)
    );

    always #5 clk = ~clk;

    int         testsRun = 0;
    int         testsFailed = 0;
    int         ovfCount = 0;
    logic [8:0] expQ[$];
    bit         randReady = 1'b0;
    bit         readyLevel = 1'b1;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Reference CRC: shift-left register with polynomial mask 0x8005, data LSB-first
    function automatic logic [15:0] crcByte(input logic [15:0] crc, input logic [7:0] b);
        logic [15:0] c;
        logic        f;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            f = b[i] ^ c[15];
            c = {c[14:0], 1'b0} ^ (f ? 16'h8005 : 16'h0000);
        end
        return c;
    endfunction

    function automatic logic [7:0] bitrev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.out_ready = randReady ? 1'($urandom_range(0, 1)) : readyLevel;
        end
    end

    initial begin
        logic [15:0] runCrc;
        logic        stalled;
        logic [8:0]  held;
        logic [8:0]  got;
        logic [8:0]  exp;
        runCrc  = 16'hFFFF;
        stalled = 1'b0;
        held    = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stalled = 1'b0;
                runCrc  = 16'hFFFF;
                continue;
            end
            if (overflow) ovfCount++;
            if (!busy) runCrc = 16'hFFFF;
            got = {bus.out_last, bus.out_data};
            if (stalled) checkOutput("stall_hold", {22'd0, bus.out_valid, got}, {22'd0, 1'b1, held});
            stalled = bus.out_valid && !bus.out_ready;
            held    = got;
            if (bus.out_valid && bus.out_ready) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_out", {23'd0, got}, 32'hFFFF_FFFF);
                end else begin
                    exp = expQ.pop_front();
                    checkOutput("out_byte", {23'd0, got}, {23'd0, exp});
                end
                runCrc = crcByte(runCrc, bus.out_data);
                if (bus.out_last) begin
                    checkOutput("crc_residual", {16'd0, runCrc}, 32'h800D);
                    runCrc = 16'hFFFF;
                end
            end
        end
    end

    task automatic pulse(input bit s, input bit z, input bit a);
        @(posedge clk);
        #1;
        start = s;
        startZlp = z;
        abort = a;
        @(posedge clk);
        #1;
        start = 1'b0;
        startZlp = 1'b0;
        abort = 1'b0;
    endtask

    task automatic sendByte(input logic [7:0] d, input bit last);
        int n;
        bit taken;
        n = 0;
        taken = 1'b0;
        bus.in_data  = d;
        bus.in_last  = last;
        bus.in_valid = 1'b1;
        while (!taken && n < 200) begin
            @(negedge clk);
            taken = bus.in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        checkOutput("in_accept", {31'd0, taken}, 32'd1);
    endtask

    task automatic applyStimulus(input logic [7:0] data[8], input int len, input bit withLast);
        logic [15:0] crc;
        crc = 16'hFFFF;
        pulse(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < len; i++) begin
            expQ.push_back({1'b0, data[i]});
            crc = crcByte(crc, data[i]);
            sendByte(data[i], withLast && (i == len - 1));
        end
        if (withLast) begin
            expQ.push_back({1'b0, ~bitrev8(crc[15:8])});
            expQ.push_back({1'b1, ~bitrev8(crc[7:0])});
        end
    endtask

    task automatic waitIdle(input string tag);
        int n;
        n = 0;
        while ((expQ.size() != 0 || busy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_idle"}, {31'd0, n < 3000}, 32'd1);
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] d[8];
        int         ovfBase;
        bus.in_data  = 8'h00;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;

        #12;
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        checkOutput("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        checkOutput("rst_byte_count", {22'd0, byteCount}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // T1: zero-length packet emits CRC of an empty payload
        readyLevel = 1'b1;
        expQ.push_back(9'h000);
        expQ.push_back(9'h100);
        pulse(1'b0, 1'b1, 1'b0);
        waitIdle("t1");
        checkOutput("t1_busy", {31'd0, busy}, 32'd0);
        checkOutput("t1_count", {22'd0, byteCount}, 32'd0);

        // T2 and T3: four-byte packet, then the same under random backpressure
        d = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00};
        applyStimulus(d, 4, 1'b1);
        waitIdle("t2");
        checkOutput("t2_count", {22'd0, byteCount}, 32'd4);
        randReady = 1'b1;
        applyStimulus(d, 4, 1'b1);
        waitIdle("t3");
        checkOutput("t3_count", {22'd0, byteCount}, 32'd4);
        randReady = 1'b0;

        // T4: a fifth byte beyond MAX_BYTES drops the packet with no CRC
        d = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00};
        applyStimulus(d, 4, 1'b0);
        ovfBase = ovfCount;
        bus.in_data  = 8'h50;
        bus.in_valid = 1'b1;
        for (int n = 0; n < 200 && busy; n++) @(negedge clk);
        bus.in_valid = 1'b0;
        waitIdle("t4");
        repeat (2) @(posedge clk);
        #1;
        checkOutput("t4_overflow", ovfCount - ovfBase, 32'd1);
        checkOutput("t4_busy", {31'd0, busy}, 32'd0);

        // T5: abort during the second byte's shift, then a clean single-byte packet
        pulse(1'b1, 1'b0, 1'b0);
        expQ.push_back({1'b0, 8'h11});
        sendByte(8'h11, 1'b0);
        sendByte(8'h22, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        @(negedge clk);
        checkOutput("t5_abort_busy", {31'd0, busy}, 32'd0);
        checkOutput("t5_abort_valid", {31'd0, bus.out_valid}, 32'd0);
        checkOutput("t5_abort_count", {22'd0, byteCount}, 32'd0);
        checkOutput("t5_abort_queue", expQ.size(), 32'd0);
        d = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        applyStimulus(d, 1, 1'b1);
        waitIdle("t5");
        checkOutput("t5_count", {22'd0, byteCount}, 32'd1);
        pulse(1'b1, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("t5_start_abort_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        checkOutput("t5_start_abort_busy2", {31'd0, busy}, 32'd0);

        // T6: asynchronous reset while the low CRC byte waits on the serializer
        readyLevel = 1'b0;
        @(posedge clk);
        expQ.push_back(9'h000);
        expQ.push_back(9'h100);
        pulse(1'b0, 1'b1, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        checkOutput("t6_waiting", {30'd0, bus.out_valid, busy}, 32'd3);
        rst_n = 1'b0;
        #1;
        checkOutput("t6_out_valid", {31'd0, bus.out_valid}, 32'd0);
        checkOutput("t6_out_data", {24'd0, bus.out_data}, 32'd0);
        checkOutput("t6_out_last", {31'd0, bus.out_last}, 32'd0);
        checkOutput("t6_busy", {31'd0, busy}, 32'd0);
        checkOutput("t6_in_ready", {31'd0, bus.in_ready}, 32'd0);
        checkOutput("t6_overflow", {31'd0, overflow}, 32'd0);
        expQ.delete();
        readyLevel = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        d = '{8'h5A, 8'hC3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        applyStimulus(d, 2, 1'b1);
        waitIdle("t6");
        checkOutput("t6_count", {22'd0, byteCount}, 32'd2);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
